// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises a push-button reset, stretches it, then releases reset_out bits in ascending order.
// Optional soft re-sequence input is enabled by defining RESET_SEQ_SOFT_REQ_EN.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int NUM_OUTPUTS    = 4
) (
  input  logic                   clock,
  input  logic                   reset_in_n,
`ifdef RESET_SEQ_SOFT_REQ_EN
  input  logic                   soft_reset_req,
`endif
  output logic [NUM_OUTPUTS-1:0] reset_out,
  output logic                   reset_done
);

  localparam int MAX_CYCLES = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W      = $clog2(NUM_OUTPUTS + 1);

  localparam logic [CNT_W-1:0] STRETCH_END = CNT_W'(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] STAGGER_END = CNT_W'(STAGGER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {
    HOLD,
    STRETCH,
    STAGGER,
    DONE
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       next_cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       next_idx;
  logic [NUM_OUTPUTS-1:0] next_reset_out;
  logic                   next_done;
  logic                   soft_req;
  logic                   sync_released;

`ifdef RESET_SEQ_SOFT_REQ_EN
  assign soft_req = soft_reset_req;
`else
  assign soft_req = 1'b0;
`endif

  assign sync_released = ~sync_q[SYNC_STAGES-1];

  // Every flop presets asynchronously; release only propagates through the synchroniser chain.
  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      sync_q     <= '1;
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      reset_out  <= '1;
      reset_done <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], 1'b0};
      state      <= next_state;
      cnt        <= next_cnt;
      idx        <= next_idx;
      reset_out  <= next_reset_out;
      reset_done <= next_done;
    end
  end

  // Leaving HOLD preloads the counter with 1 since the HOLD exit edge already counts toward the stretch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_idx   = idx;
    if (soft_req) begin
      next_state = STRETCH;
      next_cnt   = '0;
      next_idx   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (sync_released) begin
            next_state = STRETCH;
            next_cnt   = CNT_ONE;
          end
        end
        STRETCH: begin
          if (cnt == STRETCH_END) begin
            next_idx   = IDX_ONE;
            next_cnt   = CNT_ONE;
            next_state = (NUM_OUTPUTS == 1) ? DONE : STAGGER;
          end else begin
            next_cnt = cnt + CNT_ONE;
          end
        end
        STAGGER: begin
          if (cnt == STAGGER_END) begin
            next_cnt = CNT_ONE;
            next_idx = idx + IDX_ONE;
            if (idx == LAST_IDX) begin
              next_state = DONE;
            end
          end else begin
            next_cnt = cnt + CNT_ONE;
          end
        end
        DONE: begin
        end
        default: begin
          next_state = HOLD;
          next_cnt   = '0;
          next_idx   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies change on the transition edge.
  always_comb begin
    next_reset_out = '1;
    next_done      = 1'b0;
    case (next_state)
      STAGGER: begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          if (i < int'(next_idx)) begin
            next_reset_out[i] = 1'b0;
          end
        end
      end
      DONE: begin
        next_reset_out = '0;
        next_done      = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3: synchroniser depth, legal 2..8.
REQ-002 SHALL have parameter STRETCH_CYCLES, default 16: hold time after synchronised release, legal 1..65535.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 4: spacing between successive output releases, legal 1..65535.
REQ-004 SHALL have parameter NUM_OUTPUTS, default 4: number of reset domains released in order, legal 1..16.
REQ-005 SHALL have port clock, input, 1: system clock, the only clock.
REQ-006 SHALL have port reset_in_n, input, 1: asynchronous, active-low reset from push button.
REQ-007 SHALL have port soft_reset_req, input, 1: synchronous active-high re-sequence request (present only per REQ-026).
REQ-008 SHALL have port reset_out, output, NUM_OUTPUTS: active-high resets; bit 0 released first.
REQ-009 SHALL have port reset_done, output, 1: high when every reset_out bit is released.

Function
REQ-010 Synchroniser SHALL be a chain of SYNC_STAGES flops, D of the first tied to 0, all preset to 1 asynchronously by reset_in_n low.
REQ-011 FSM SHALL have states HOLD, STRETCH, STAGGER, DONE.
REQ-012 HOLD: all reset_out high; go to STRETCH on the edge the synchroniser output is sampled low.
REQ-013 STRETCH: counter runs; leave STRETCH and deassert reset_out[0] so that it falls exactly SYNC_STAGES+STRETCH_CYCLES rising edges after the first edge sampling reset_in_n high.
REQ-014 STAGGER: reset_out[i] SHALL fall exactly STAGGER_CYCLES edges after reset_out[i-1]; bits only fall in ascending index order.
REQ-015 DONE entered on the edge reset_out[NUM_OUTPUTS-1] falls; reset_done rises on that same edge, stays high until next reset.
REQ-016 NUM_OUTPUTS=1: STAGGER skipped; reset_done rises with reset_out[0].
REQ-017 All deassertions SHALL be synchronous to clock rising edge; no output glitches (all outputs registered).
REQ-018 Counter width SHALL be clog2 of max(STRETCH_CYCLES, STAGGER_CYCLES)+1; no wrap-around permitted at maximum parameter values.
REQ-019 reset_in_n low at any time, any state: all reset_out high and reset_done low asynchronously, FSM to HOLD, counter cleared.
REQ-020 reset_in_n pulse shorter than one clock period SHALL still produce a full sequence (preset is level-asynchronous).

Reset
REQ-021 During reset_in_n low: reset_out = all ones, reset_done = 0, state = HOLD, counter = 0.
REQ-022 Power-up value of every flop SHALL equal its reset value (reset_out all ones).
REQ-023 Reset assertion SHALL be asynchronous; deassertion only through the synchroniser.

Configuration
REQ-024 Macro RESET_SEQ_SOFT_REQ_EN SHALL select soft reset support.
REQ-025 Without macro: soft_reset_req port absent; behaviour per REQ-010..REQ-023 only.
REQ-026 With macro: soft_reset_req present; sampled high on an edge in any state SHALL set all reset_out high and reset_done low on that edge, clear counter, enter STRETCH; sequence then follows REQ-013/014 timed from that edge (reset_out[0] falls STRETCH_CYCLES+1 edges later).
REQ-027 With macro: soft_reset_req held high SHALL keep state in STRETCH with counter at 0; reset_in_n low dominates soft_reset_req.

Verification (SYNC_STAGES=3, STRETCH_CYCLES=8, STAGGER_CYCLES=4, NUM_OUTPUTS=4)
REQ-028 Power-up, reset_in_n high from edge 0 -> reset_out[0] falls edge 11, [1] 15, [2] 19, [3] 23; reset_done rises edge 23.
REQ-029 reset_in_n low mid-clock at edge 17 during STAGGER -> reset_out=4'hF, reset_done=0 immediately, before next edge; full sequence restarts on release.
REQ-030 reset_in_n low pulse 2 ns wide in DONE -> reset_out=4'hF asynchronously; full 23-edge sequence repeats.
REQ-031 With RESET_SEQ_SOFT_REQ_EN, soft_reset_req 1-cycle pulse at edge 40 in DONE -> reset_out=4'hF at edge 40; reset_out[0] falls edge 49, reset_done rises edge 61.
REQ-032 With RESET_SEQ_SOFT_REQ_EN, soft_reset_req and reset_in_n low together -> reset_in_n dominates; sequence timed from reset_in_n release per REQ-028.
REQ-033 NUM_OUTPUTS=1, STRETCH_CYCLES=1 -> reset_out[0] and reset_done change on edge 4 after release.
